// File: rtl/ysyx_23060203_flush_ctrl_pkg.sv
// Shared types and constants for the write-back flush sequencer.
// Optional counter bank enabled by YSYX_23060203_FLUSH_PERF_EN.
package ysyx_23060203_pkg;

   typedef enum logic [2:0] {
      BOOT,
      IDLE,
      DRAIN,
      INVAL,
      REDIR
   } flush_state_t;

   localparam int          XLEN_DEF     = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h3000_0000;

endpackage

// File: rtl/ysyx_23060203_flush_ctrl_if.sv
// Flush/redirect bundle between write-back, LSU, I-cache, IFU and the
// flush sequencer (slave side is the sequencer).
interface ysyx_23060203_flush_ctrl_if #(
   parameter int XLEN = 32
);

   logic            cs_flush;
   logic [XLEN-1:0] cs_dnpc;
   logic            fencei;
   logic            lsu_busy;
   logic            pipe_flush;
   logic            icache_inv_req;
   logic            icache_inv_ack;
   logic            redir_valid;
   logic            redir_ready;
   logic [XLEN-1:0] redir_pc;
   logic            busy;

   modport master (
      output cs_flush, cs_dnpc, fencei, lsu_busy,
      output icache_inv_ack, redir_ready,
      input  pipe_flush, icache_inv_req, redir_valid,
      input  redir_pc, busy
   );

   modport slave (
      input  cs_flush, cs_dnpc, fencei, lsu_busy,
      input  icache_inv_ack, redir_ready,
      output pipe_flush, icache_inv_req, redir_valid,
      output redir_pc, busy
   );

endinterface

// File: rtl/ysyx_23060203_perf_cnt.sv
// Wrap-around event counters for flush activity; only built when
// YSYX_23060203_FLUSH_PERF_EN is defined.
module ysyx_23060203_perf_cnt (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush_acc,
   input  logic        fencei_acc,
   input  logic        stall,
   output logic [31:0] flush_cnt,
   output logic [31:0] fencei_cnt,
   output logic [31:0] stall_cyc
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         flush_cnt  <= '0;
         fencei_cnt <= '0;
         stall_cyc  <= '0;
      end else begin
         if (flush_acc)  flush_cnt  <= flush_cnt + 32'd1;
         if (fencei_acc) fencei_cnt <= fencei_cnt + 32'd1;
         if (stall)      stall_cyc  <= stall_cyc + 32'd1;
      end
   end

endmodule

// File: rtl/ysyx_23060203_flush_ctrl.sv
// Flush/redirect sequencer: kill front end, drain LSU, invalidate I-cache
// on fence.i, redirect IFU. Counters under YSYX_23060203_FLUSH_PERF_EN.
module ysyx_23060203_flush_ctrl
   import ysyx_23060203_pkg::*;
#(
   parameter int              XLEN     = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
   input  logic clock,
   input  logic reset,
   ysyx_23060203_flush_ctrl_if.slave bus
`ifdef YSYX_23060203_FLUSH_PERF_EN
   ,
   output logic [31:0] perf_flush_cnt,
   output logic [31:0] perf_fencei_cnt,
   output logic [31:0] perf_stall_cyc
`endif
);

   flush_state_t    state, state_nxt;
   logic            valid_q, valid_d;
   logic            req_q, req_d;
   logic            flag_q, flag_d;
   logic            busy_q;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            hs;

   assign hs = valid_q & bus.redir_ready;

   always_comb begin
      state_nxt = state;
      valid_d   = valid_q;
      req_d     = req_q;
      flag_d    = flag_q;
      pc_d      = pc_q;
      unique case (state)
         BOOT: begin
            if (hs) begin
               valid_d   = 1'b0;
               state_nxt = IDLE;
            end else begin
               valid_d = 1'b1;
            end
         end
         IDLE: begin
            if (bus.cs_flush) begin
               pc_d   = bus.cs_dnpc;
               flag_d = bus.fencei;
               if (bus.lsu_busy) begin
                  state_nxt = DRAIN;
               end else if (bus.fencei) begin
                  state_nxt = INVAL;
                  req_d     = 1'b1;
               end else begin
                  state_nxt = REDIR;
                  valid_d   = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (!bus.lsu_busy) begin
               if (flag_q) begin
                  state_nxt = INVAL;
                  req_d     = 1'b1;
               end else begin
                  state_nxt = REDIR;
                  valid_d   = 1'b1;
               end
            end
         end
         INVAL: begin
            if (req_q && bus.icache_inv_ack) begin
               req_d     = 1'b0;
               state_nxt = REDIR;
               valid_d   = 1'b1;
            end
         end
         REDIR: begin
            if (hs) begin
               valid_d   = 1'b0;
               flag_d    = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = BOOT;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= BOOT;
         valid_q <= 1'b0;
         req_q   <= 1'b0;
         flag_q  <= 1'b0;
         busy_q  <= 1'b1;
         pc_q    <= RESET_PC;
      end else begin
         state   <= state_nxt;
         valid_q <= valid_d;
         req_q   <= req_d;
         flag_q  <= flag_d;
         busy_q  <= (state_nxt != IDLE);
         pc_q    <= pc_d;
      end
   end

   // Zero-latency kill: the flush cycle itself already holds the front end.
   assign bus.pipe_flush     = (state != IDLE) | bus.cs_flush;
   assign bus.icache_inv_req = req_q;
   assign bus.redir_valid    = valid_q;
   assign bus.redir_pc       = pc_q;
   assign bus.busy           = busy_q;

`ifdef YSYX_23060203_FLUSH_PERF_EN
   logic flush_acc, fencei_acc, stall;

   assign flush_acc  = (state == IDLE) & bus.cs_flush;
   assign fencei_acc = flush_acc & bus.fencei;
   assign stall      = (state == DRAIN) | (state == INVAL) |
                       (state == REDIR);

   ysyx_23060203_perf_cnt u_perf (
      .clock      (clock),
      .reset      (reset),
      .flush_acc  (flush_acc),
      .fencei_acc (fencei_acc),
      .stall      (stall),
      .flush_cnt  (perf_flush_cnt),
      .fencei_cnt (perf_fencei_cnt),
      .stall_cyc  (perf_stall_cyc)
   );
`endif

endmodule

// File: tb/tb_ysyx_23060203_flush_ctrl.sv
// Scenario bench for the flush sequencer; redirect targets are
// scoreboarded in a queue and popped at each observed redirect.
module tb_ysyx_23060203_flush_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   ysyx_23060203_flush_ctrl_if #(.XLEN(32)) bus ();

`ifdef YSYX_23060203_FLUSH_PERF_EN
   logic [31:0] pf_flush, pf_fencei, pf_stall;
`endif

   ysyx_23060203_flush_ctrl dut (
      .clock (clk),
      .reset (rst_n),
      .bus   (bus)
`ifdef YSYX_23060203_FLUSH_PERF_EN
      ,
      .perf_flush_cnt  (pf_flush),
      .perf_fencei_cnt (pf_fencei),
      .perf_stall_cyc  (pf_stall)
`endif
   );

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_pc;

   task automatic test_reset();
      rst_n              = 1'b0;
      bus.cs_flush       = 1'b0;
      bus.cs_dnpc        = '0;
      bus.fencei         = 1'b0;
      bus.lsu_busy       = 1'b0;
      bus.icache_inv_ack = 1'b0;
      bus.redir_ready    = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.redir_valid, bus.icache_inv_req, bus.busy,
           bus.pipe_flush} !== 4'b0011) begin
         errors++;
         $display("FAIL reset_outputs: got v/req/busy/pf=%b%b%b%b want 0011",
                  bus.redir_valid, bus.icache_inv_req, bus.busy,
                  bus.pipe_flush);
      end
      checks++;
      if (bus.redir_pc !== 32'h3000_0000) begin
         errors++;
         $display("FAIL reset_pc: got %h want 30000000", bus.redir_pc);
      end
      exp_q.push_back(32'h3000_0000);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.redir_valid !== 1'b1) begin
         errors++;
         $display("FAIL boot_valid: got %b want 1", bus.redir_valid);
      end
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL boot_pc: got %h, no expected entry", bus.redir_pc);
      end else begin
         exp_pc = exp_q.pop_front();
         if (bus.redir_pc !== exp_pc) begin
            errors++;
            $display("FAIL boot_pc: got %h want %h", bus.redir_pc, exp_pc);
         end
      end
      @(negedge clk);
      checks++;
      if ({bus.redir_valid, bus.busy, bus.pipe_flush} !== 3'b000) begin
         errors++;
         $display("FAIL boot_idle: got v/busy/pf=%b%b%b want 000",
                  bus.redir_valid, bus.busy, bus.pipe_flush);
      end
   endtask

   task automatic test_plain_flush(input logic [31:0] pc);
      bus.cs_flush    = 1'b1;
      bus.cs_dnpc     = pc;
      bus.fencei      = 1'b0;
      bus.lsu_busy    = 1'b0;
      bus.redir_ready = 1'b1;
      exp_q.push_back(pc);
      #1;
      checks++;
      if ({bus.pipe_flush, bus.busy} !== 2'b10) begin
         errors++;
         $display("FAIL plain_same_cycle: got pf/busy=%b%b want 10",
                  bus.pipe_flush, bus.busy);
      end
      @(negedge clk);
      bus.cs_flush = 1'b0;
      checks++;
      if ({bus.redir_valid, bus.busy} !== 2'b11) begin
         errors++;
         $display("FAIL plain_redir: got v/busy=%b%b want 11",
                  bus.redir_valid, bus.busy);
      end
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL plain_pc: got %h, no expected entry", bus.redir_pc);
      end else begin
         exp_pc = exp_q.pop_front();
         if (bus.redir_pc !== exp_pc) begin
            errors++;
            $display("FAIL plain_pc: got %h want %h", bus.redir_pc, exp_pc);
         end
      end
      @(negedge clk);
      checks++;
      if ({bus.redir_valid, bus.busy, bus.pipe_flush} !== 3'b000) begin
         errors++;
         $display("FAIL plain_idle: got v/busy/pf=%b%b%b want 000",
                  bus.redir_valid, bus.busy, bus.pipe_flush);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++)
         test_plain_flush({$urandom_range(32'hffff), 16'h0} | 32'h8000_0004);
   endtask

   task automatic test_spurious_ack();
      bus.icache_inv_ack = 1'b1;
      @(negedge clk);
      bus.icache_inv_ack = 1'b0;
      checks++;
      if ({bus.icache_inv_req, bus.busy, bus.redir_valid} !== 3'b000) begin
         errors++;
         $display("FAIL spurious_ack: got req/busy/v=%b%b%b want 000",
                  bus.icache_inv_req, bus.busy, bus.redir_valid);
      end
   endtask

   task automatic test_fencei_drain();
      logic [3:0] exp_v;
      int         drains = 0;
      bus.cs_flush    = 1'b1;
      bus.cs_dnpc     = 32'h3000_0200;
      bus.fencei      = 1'b1;
      bus.lsu_busy    = 1'b1;
      bus.redir_ready = 1'b1;
      exp_q.push_back(32'h3000_0200);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         exp_v = {(c >= 4 && c <= 6), (c == 7), (c <= 7), (c <= 7)};
         checks++;
         if ({bus.icache_inv_req, bus.redir_valid, bus.busy,
              bus.pipe_flush} !== exp_v) begin
            errors++;
            $display("FAIL fencei_cyc%0d: got req/v/busy/pf=%b%b%b%b want %b",
                     c, bus.icache_inv_req, bus.redir_valid, bus.busy,
                     bus.pipe_flush, exp_v);
         end
         if (bus.busy && !bus.icache_inv_req && !bus.redir_valid)
            drains++;
         if (bus.redir_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL fencei_pc: got %h, no expected entry",
                        bus.redir_pc);
            end else begin
               exp_pc = exp_q.pop_front();
               if (bus.redir_pc !== exp_pc) begin
                  errors++;
                  $display("FAIL fencei_pc: got %h want %h",
                           bus.redir_pc, exp_pc);
               end
            end
         end
         bus.cs_flush       = 1'b0;
         bus.fencei         = 1'b0;
         bus.lsu_busy       = (c < 3);
         bus.icache_inv_ack = (c == 6);
      end
      checks++;
      if (drains != 3) begin
         errors++;
         $display("FAIL fencei_drain_cycles: got %0d want 3", drains);
      end
   endtask

   task automatic test_redir_stall();
      bus.redir_ready = 1'b0;
      bus.cs_flush    = 1'b1;
      bus.cs_dnpc     = 32'h3000_0300;
      bus.fencei      = 1'b0;
      bus.lsu_busy    = 1'b0;
      exp_q.push_back(32'h3000_0300);
      for (int c = 1; c <= 6; c++) begin
         @(negedge clk);
         checks++;
         if ({bus.icache_inv_req, bus.redir_valid, bus.busy} !==
             {1'b0, (c <= 5), (c <= 5)}) begin
            errors++;
            $display("FAIL stall_cyc%0d: got req/v/busy=%b%b%b want 0%b%b",
                     c, bus.icache_inv_req, bus.redir_valid, bus.busy,
                     (c <= 5), (c <= 5));
         end
         if (c <= 5) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL stall_pc%0d: got %h, no expected entry",
                        c, bus.redir_pc);
            end else if (bus.redir_pc !== exp_q[0]) begin
               errors++;
               $display("FAIL stall_pc%0d: got %h want %h",
                        c, bus.redir_pc, exp_q[0]);
            end
         end
         if (c == 5 && exp_q.size() != 0)
            exp_pc = exp_q.pop_front();
         bus.cs_flush    = (c == 2);
         bus.fencei      = (c == 2);
         bus.cs_dnpc     = (c == 2) ? 32'h3000_0bad : 32'h3000_0300;
         bus.redir_ready = (c >= 5);
      end
      bus.cs_flush = 1'b0;
      bus.fencei   = 1'b0;
      checks++;
      if (bus.redir_pc !== 32'h3000_0300) begin
         errors++;
         $display("FAIL stall_spurious_pc: got %h want 30000300",
                  bus.redir_pc);
      end
   endtask

   task automatic test_reset_mid_inval();
      bus.redir_ready = 1'b1;
      bus.cs_flush    = 1'b1;
      bus.cs_dnpc     = 32'h3000_0400;
      bus.fencei      = 1'b1;
      bus.lsu_busy    = 1'b0;
      @(negedge clk);
      bus.cs_flush = 1'b0;
      bus.fencei   = 1'b0;
      checks++;
      if (bus.icache_inv_req !== 1'b1) begin
         errors++;
         $display("FAIL inval_req: got %b want 1", bus.icache_inv_req);
      end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.icache_inv_req, bus.redir_valid, bus.busy} !== 3'b001) begin
         errors++;
         $display("FAIL async_abort: got req/v/busy=%b%b%b want 001",
                  bus.icache_inv_req, bus.redir_valid, bus.busy);
      end
      @(negedge clk);
      exp_q.push_back(32'h3000_0000);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.redir_valid !== 1'b1 || exp_q.size() == 0) begin
         errors++;
         $display("FAIL reboot_valid: got %b want 1 (queue %0d)",
                  bus.redir_valid, exp_q.size());
      end else begin
         exp_pc = exp_q.pop_front();
         if (bus.redir_pc !== exp_pc) begin
            errors++;
            $display("FAIL reboot_pc: got %h want %h", bus.redir_pc, exp_pc);
         end
      end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reboot_idle: got busy=%b want 0", bus.busy);
      end
   endtask

`ifdef YSYX_23060203_FLUSH_PERF_EN
   task automatic test_perf();
      test_plain_flush(32'h3000_1000);
      test_plain_flush(32'h3000_2000);
      bus.cs_flush    = 1'b1;
      bus.cs_dnpc     = 32'h3000_3000;
      bus.fencei      = 1'b1;
      bus.lsu_busy    = 1'b1;
      bus.redir_ready = 1'b1;
      @(negedge clk);
      bus.cs_flush = 1'b0;
      bus.fencei   = 1'b0;
      bus.lsu_busy = 1'b0;
      @(negedge clk);
      bus.icache_inv_ack = 1'b1;
      @(negedge clk);
      bus.icache_inv_ack = 1'b0;
      @(negedge clk);
      checks++;
      if ({pf_flush, pf_fencei, pf_stall} !== {32'd3, 32'd1, 32'd5}) begin
         errors++;
         $display("FAIL perf_cnt: got %0d/%0d/%0d want 3/1/5",
                  pf_flush, pf_fencei, pf_stall);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_plain_flush(32'h3000_0104);
      test_back_to_back();
      test_spurious_ack();
      test_fencei_drain();
      test_redir_stall();
      test_reset_mid_inval();
`ifdef YSYX_23060203_FLUSH_PERF_EN
      test_perf();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
